// File: rtl/spi_reg_pkg.sv
// Address map and defaults for the SPI-facing register bank.
// Host-side test software headers mirror these constants.
package spi_reg_pkg;

  localparam logic [15:0] ADDR_ID       = 16'h0000;
  localparam logic [15:0] ADDR_SCRATCH  = 16'h0001;
  localparam logic [15:0] ADDR_INT_PEND = 16'h0002;
  localparam logic [15:0] ADDR_INT_MASK = 16'h0003;
  localparam logic [15:0] ADDR_STATUS   = 16'h0004;
  localparam logic [15:0] ADDR_WR_CNT   = 16'h0005;
  localparam logic [15:0] ADDR_ERR_CNT  = 16'h0006;
  localparam logic [15:0] CTRL_BASE     = 16'h0010;

  localparam logic [15:0] DEF_ID_VALUE  = 16'h4A45;

  // Classification of the write strobe in a given cycle
  typedef enum logic [1:0] {
    WR_NONE,
    WR_ACCEPT,
    WR_REJECT
  } wr_kind_e;

  // Writable targets are SCRATCH, INT_PEND, INT_MASK and the control array;
  // everything else (RO or unmapped) is rejected and counted as an error.
  function automatic wr_kind_e wr_classify(input logic        en,
                                           input logic [15:0] addr,
                                           input int unsigned num_ctrl);
    logic [15:0] off;
    off = addr - CTRL_BASE;
    if (!en)
      return WR_NONE;
    if (addr == ADDR_SCRATCH || addr == ADDR_INT_PEND || addr == ADDR_INT_MASK)
      return WR_ACCEPT;
    if (addr >= CTRL_BASE && off < 16'(num_ctrl))
      return WR_ACCEPT;
    return WR_REJECT;
  endfunction

endpackage

// File: rtl/spi_reg_irq.sv
// Interrupt pending/mask registers with a registered level interrupt output.
module spi_reg_irq
  import spi_reg_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] evt_i,
  input  logic [15:0] clr_i,
  input  logic        mask_we_i,
  input  logic [15:0] mask_i,
  output logic [15:0] pend_o,
  output logic [15:0] mask_o,
  output logic        irq_o
);

  logic [15:0] pend_q, pend_d;
  logic [15:0] mask_q, mask_d;
  logic        irq_q, irq_d;

  // Next state: a same-cycle event beats a W1C clear on the same bit
  always_comb begin
    pend_d = (pend_q & ~clr_i) | evt_i;
    mask_d = mask_we_i ? mask_i : mask_q;
    irq_d  = |(pend_q & mask_q);
  end

  // State registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave frame decoder: ID, scratch, interrupt,
// status, write/error counters and a parameterised control register array.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_CTRL = 16,
  parameter logic [15:0] ID_VALUE = DEF_ID_VALUE,
  parameter logic [15:0] CTRL_RST = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     set_wr_en,
  input  logic [15:0]              set_wr_addr,
  input  logic [15:0]              set_wr_data,
  input  logic                     set_rd_en,
  input  logic [15:0]              set_rd_addr,
  output logic [15:0]              set_rd_data,
  input  logic [15:0]              evt_i,
  input  logic [15:0]              sts_i,
  output logic [16*NUM_CTRL-1:0]   ctrl_o,
  output logic [NUM_CTRL-1:0]      ctrl_upd_o,
  output logic                     fpga_int_out
);

  logic [15:0]         scratch_q, scratch_d;
  logic [15:0]         status_q;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic [15:0]         ctrl_q [NUM_CTRL];
  logic [15:0]         ctrl_d [NUM_CTRL];
  logic [NUM_CTRL-1:0] upd_q, upd_d;

  logic [15:0] pend_clr;
  logic        mask_we;
  logic [15:0] int_pend, int_mask;
  logic        irq;
  wr_kind_e    wr_kind;
  logic [15:0] wr_off, rd_off;

  // Reads are purely address-driven; the decoder keeps this strobe low
  logic unused_rd_en;
  assign unused_rd_en = set_rd_en;

  assign wr_kind = wr_classify(set_wr_en, set_wr_addr, NUM_CTRL);
  assign wr_off  = set_wr_addr - CTRL_BASE;
  assign rd_off  = set_rd_addr - CTRL_BASE;

  spi_reg_irq u_irq (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .evt_i     (evt_i),
    .clr_i     (pend_clr),
    .mask_we_i (mask_we),
    .mask_i    (set_wr_data),
    .pend_o    (int_pend),
    .mask_o    (int_mask),
    .irq_o     (irq)
  );

  // Write decode, counter next state and control array updates
  always_comb begin
    scratch_d = scratch_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    ctrl_d    = ctrl_q;
    upd_d     = '0;
    pend_clr  = '0;
    mask_we   = 1'b0;
    if (wr_kind == WR_ACCEPT)
      wr_cnt_d = wr_cnt_q + 16'd1;
    if (wr_kind == WR_REJECT && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 16'd1;
    if (set_wr_en) begin
      if (set_wr_addr == ADDR_SCRATCH)  scratch_d = set_wr_data;
      if (set_wr_addr == ADDR_INT_PEND) pend_clr  = set_wr_data;
      if (set_wr_addr == ADDR_INT_MASK) mask_we   = 1'b1;
      for (int unsigned k = 0; k < NUM_CTRL; k++) begin
        if (set_wr_addr >= CTRL_BASE && wr_off == 16'(k)) begin
          ctrl_d[k] = set_wr_data;
          upd_d[k]  = 1'b1;
        end
      end
    end
  end

  // Read mux over current register values, so a same-cycle write reads old
  always_comb begin
    rd_data_d = '0;
    case (set_rd_addr)
      ADDR_ID:       rd_data_d = ID_VALUE;
      ADDR_SCRATCH:  rd_data_d = scratch_q;
      ADDR_INT_PEND: rd_data_d = int_pend;
      ADDR_INT_MASK: rd_data_d = int_mask;
      ADDR_STATUS:   rd_data_d = status_q;
      ADDR_WR_CNT:   rd_data_d = wr_cnt_q;
      ADDR_ERR_CNT:  rd_data_d = err_cnt_q;
      default: begin
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
          if (set_rd_addr >= CTRL_BASE && rd_off == 16'(k))
            rd_data_d = ctrl_q[k];
        end
      end
    endcase
  end

  // Register state; reset wins over any same-cycle write strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scratch_q <= '0;
      status_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      rd_data_q <= '0;
      upd_q     <= '0;
      for (int unsigned k = 0; k < NUM_CTRL; k++)
        ctrl_q[k] <= CTRL_RST;
    end else begin
      scratch_q <= scratch_d;
      status_q  <= sts_i;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      rd_data_q <= rd_data_d;
      upd_q     <= upd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Flatten the control array onto the output bus
  always_comb begin
    ctrl_o = '0;
    for (int unsigned k = 0; k < NUM_CTRL; k++)
      ctrl_o[16*k +: 16] = ctrl_q[k];
  end

  assign set_rd_data  = rd_data_q;
  assign ctrl_upd_o   = upd_q;
  assign fpga_int_out = irq;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: inputs driven and outputs checked on the
// falling clock edge, expected values hand-computed.
module tb_spi_reg_bank;

  localparam int unsigned NC = 16;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              set_wr_en = 1'b0;
  logic [15:0]       set_wr_addr = '0;
  logic [15:0]       set_wr_data = '0;
  logic              set_rd_en = 1'b0;
  logic [15:0]       set_rd_addr = '0;
  logic [15:0]       set_rd_data;
  logic [15:0]       evt_i = '0;
  logic [15:0]       sts_i = '0;
  logic [16*NC-1:0]  ctrl_o;
  logic [NC-1:0]     ctrl_upd_o;
  logic              fpga_int_out;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_wr = '0;
  logic [15:0] exp_err = '0;
  logic [16*NC-1:0] exp_ctrl;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .NUM_CTRL (NC),
    .ID_VALUE (16'h4A45),
    .CTRL_RST (16'h0000)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .set_wr_en    (set_wr_en),
    .set_wr_addr  (set_wr_addr),
    .set_wr_data  (set_wr_data),
    .set_rd_en    (set_rd_en),
    .set_rd_addr  (set_rd_addr),
    .set_rd_data  (set_rd_data),
    .evt_i        (evt_i),
    .sts_i        (sts_i),
    .ctrl_o       (ctrl_o),
    .ctrl_upd_o   (ctrl_upd_o),
    .fpga_int_out (fpga_int_out)
  );

  function automatic bit accepted(input logic [15:0] a);
    return (a == 16'h0001) || (a == 16'h0002) || (a == 16'h0003) ||
           (a >= 16'h0010 && a <= 16'h001F);
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [16*NC-1:0] obs, input logic [16*NC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; called and returns on a falling edge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    set_wr_en = 1'b1; set_wr_addr = a; set_wr_data = d;
    @(negedge clk);
    set_wr_en = 1'b0;
    if (accepted(a)) exp_wr = exp_wr + 16'd1;
    else if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    set_rd_addr = a;
    @(negedge clk);
    check16(tag, set_rd_data, exp);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    check16("rst_rd_data", set_rd_data, 16'h0000);
    check16("rst_int", {15'd0, fpga_int_out}, 16'h0000);
    checkw("rst_ctrl", ctrl_o, '0);
    check16("rst_upd", ctrl_upd_o, 16'h0000);
    rd("rd_id", 16'h0000, 16'h4A45);
    rd("rd_mask_rst", 16'h0003, 16'h0000);

    // Scratch write and readback
    wr(16'h0001, 16'h1234);
    rd("rd_scratch", 16'h0001, 16'h1234);
    rd("rd_wrcnt1", 16'h0005, 16'h0001);

    // Same-cycle read/write returns the old value
    set_rd_addr = 16'h0001;
    wr(16'h0001, 16'h5555);
    check16("rdwr_old", set_rd_data, 16'h1234);
    @(negedge clk);
    check16("rdwr_new", set_rd_data, 16'h5555);

    // Interrupt latency
    wr(16'h0003, 16'h0001);
    evt_i = 16'h0001;
    @(negedge clk);
    evt_i = 16'h0000;
    check16("int_lat1", {15'd0, fpga_int_out}, 16'h0000);
    @(negedge clk);
    check16("int_lat2", {15'd0, fpga_int_out}, 16'h0001);

    // W1C clear coinciding with a new event: event wins
    set_wr_en = 1'b1; set_wr_addr = 16'h0002; set_wr_data = 16'h0001; evt_i = 16'h0001;
    @(negedge clk);
    set_wr_en = 1'b0; evt_i = 16'h0000; exp_wr = exp_wr + 16'd1;
    check16("int_hold1", {15'd0, fpga_int_out}, 16'h0001);
    @(negedge clk);
    check16("int_hold2", {15'd0, fpga_int_out}, 16'h0001);
    rd("pend_kept", 16'h0002, 16'h0001);

    // Plain clear drops the interrupt two edges after the strobe
    wr(16'h0002, 16'h0001);
    check16("int_clr1", {15'd0, fpga_int_out}, 16'h0001);
    @(negedge clk);
    check16("int_clr2", {15'd0, fpga_int_out}, 16'h0000);
    rd("pend_clr", 16'h0002, 16'h0000);

    // Masked-out event sets pending but not the interrupt
    evt_i = 16'h0002;
    @(negedge clk);
    evt_i = 16'h0000;
    @(negedge clk);
    check16("int_masked", {15'd0, fpga_int_out}, 16'h0000);
    rd("pend_masked", 16'h0002, 16'h0002);
    wr(16'h0002, 16'hFFFF);
    rd("pend_clr_all", 16'h0002, 16'h0000);

    // Status: one capture stage then one read stage
    sts_i = 16'hA5C3; set_rd_addr = 16'h0004;
    @(negedge clk);
    check16("sts_lat1", set_rd_data, 16'h0000);
    @(negedge clk);
    check16("sts_lat2", set_rd_data, 16'hA5C3);

    // Control registers
    wr(16'h0013, 16'hBEEF);
    exp_ctrl = '0;
    exp_ctrl[63:48] = 16'hBEEF;
    checkw("ctrl3_val", ctrl_o, exp_ctrl);
    check16("ctrl3_upd", ctrl_upd_o, 16'h0008);
    @(negedge clk);
    check16("ctrl3_upd_off", ctrl_upd_o, 16'h0000);
    checkw("ctrl3_hold", ctrl_o, exp_ctrl);
    wr(16'h001F, 16'h0F0F);
    check16("ctrl15_upd", ctrl_upd_o, 16'h8000);
    rd("rd_ctrl3", 16'h0013, 16'hBEEF);
    rd("rd_ctrl15", 16'h001F, 16'h0F0F);
    rd("rd_wrcnt", 16'h0005, exp_wr);

    // Writes to RO / unmapped addresses
    wr(16'h0000, 16'hFFFF);
    wr(16'h0004, 16'hFFFF);
    wr(16'h7FFF, 16'hFFFF);
    rd("errcnt3", 16'h0006, 16'h0003);
    rd("wrcnt_same", 16'h0005, exp_wr);
    rd("id_kept", 16'h0000, 16'h4A45);
    rd("sts_kept", 16'h0004, 16'hA5C3);
    rd("unmapped", 16'h7FFF, 16'h0000);
    wr(16'h0020, 16'h0001);
    wr(16'h0005, 16'h0000);
    rd("ctrl_oob", 16'h0020, 16'h0000);
    rd("wrcnt_ro", 16'h0005, exp_wr);
    rd("errcnt5", 16'h0006, 16'h0005);

    // Error counter saturation
    for (int i = 0; i < 65529; i++) wr(16'h7FFF, 16'h0000);
    rd("errcnt_fffe", 16'h0006, 16'hFFFE);
    for (int i = 0; i < 4; i++) wr(16'h7FFF, 16'h0000);
    rd("errcnt_sat", 16'h0006, 16'hFFFF);
    rd("errcnt_model", 16'h0006, exp_err);

    // Reset in the middle of a write burst
    wr(16'h0001, 16'hAAAA);
    wr(16'h0003, 16'h0004);
    evt_i = 16'h0004;
    @(negedge clk);
    evt_i = 16'h0000;
    @(negedge clk);
    check16("pre_rst_int", {15'd0, fpga_int_out}, 16'h0001);
    wr(16'h0010, 16'h1111);
    wr(16'h0011, 16'h2222);
    set_wr_en = 1'b1; set_wr_addr = 16'h0012; set_wr_data = 16'h3333; reset_i = 1'b1;
    sts_i = 16'h0000;
    @(negedge clk);
    set_wr_en = 1'b0; reset_i = 1'b0;
    checkw("burst_rst_ctrl", ctrl_o, '0);
    check16("burst_rst_upd", ctrl_upd_o, 16'h0000);
    check16("burst_rst_int", {15'd0, fpga_int_out}, 16'h0000);
    check16("burst_rst_rd", set_rd_data, 16'h0000);
    rd("rst_ctrl2", 16'h0012, 16'h0000);
    rd("rst_ctrl0", 16'h0010, 16'h0000);
    rd("rst_scratch", 16'h0001, 16'h0000);
    rd("rst_mask", 16'h0003, 16'h0000);
    rd("rst_pend", 16'h0002, 16'h0000);
    rd("rst_wrcnt", 16'h0005, 16'h0000);
    rd("rst_errcnt", 16'h0006, 16'h0000);
    rd("rst_status", 16'h0004, 16'h0000);
    check16("rst_int_stay", {15'd0, fpga_int_out}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register bank sitting directly downstream of the SPI slave frame decoder. Consumes its single-cycle write strobes (set_wr_en/addr/data), returns read data on its read address (set_rd_addr → set_rd_data), and drives the FPGA interrupt line back to the host. Holds identification, scratch, control, status and interrupt registers for the rest of the fabric.

## Interface
- NUM_CTRL, 16: number of read/write control registers (1..64), mapped from CTRL_BASE.
- ID_VALUE, 16'h4A45: constant returned at address 0x0000.
- CTRL_RST, 16'h0000: reset value of every control register.

- clk_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- set_wr_en  in  1  one-cycle write strobe from the SPI decoder.
- set_wr_addr  in  16  write word address.
- set_wr_data  in  16  write data.
- set_rd_en  in  1  ignored (decoder ties it low); reads are address-driven.
- set_rd_addr  in  16  read word address, may change every cycle.
- set_rd_data  out  16  registered read data.
- evt_i  in  16  event pulses; each high cycle sets the matching INT_PEND bit.
- sts_i  in  16  live status bits from the fabric.
- ctrl_o  out  16*NUM_CTRL  flat control register contents; register k at bits [16k+15:16k].
- ctrl_upd_o  out  NUM_CTRL  one-cycle pulse per control register written.
- fpga_int_out  out  1  level interrupt to host, active high.

## Operation
- Address map (word addresses):
  - 0x0000 ID: RO, ID_VALUE.
  - 0x0001 SCRATCH: RW, reset 0.
  - 0x0002 INT_PEND: W1C; bit n set by evt_i[n].
  - 0x0003 INT_MASK: RW, reset 0 (all masked).
  - 0x0004 STATUS: RO, sts_i registered once.
  - 0x0005 WR_CNT: RO, count of accepted writes to RW/W1C registers, wraps 0xFFFF→0.
  - 0x0006 ERR_CNT: RO, count of writes to RO or unmapped addresses, saturates at 0xFFFF.
  - CTRL_BASE=0x0010 .. 0x0010+NUM_CTRL-1: CTRL[k], RW, reset CTRL_RST.
  - All other addresses: read 0x0000, writes ignored (counted in ERR_CNT).
- Write to INT_PEND clears bits where set_wr_data is 1; same-cycle evt_i on a bit being cleared wins (bit stays 1).
- Writes to WR_CNT/ERR_CNT do not clear them; they count as errors.
- Write to CTRL[k]: register updates and ctrl_upd_o[k] pulses in the cycle after the strobe, both visible simultaneously.
- fpga_int_out = registered OR of (INT_PEND & INT_MASK).

## Timing
- Reset (any cycle, including mid-frame): set_rd_data=0, ctrl_o=CTRL_RST replicated, ctrl_upd_o=0, fpga_int_out=0, INT_PEND/INT_MASK/SCRATCH/WR_CNT/ERR_CNT=0, STATUS register=0; set_wr_en in the reset cycle is dropped.
- Write: register value changes on the edge at which set_wr_en is sampled high; readable via set_rd_data 2 edges later at the earliest.
- Read: set_rd_data reflects set_rd_addr sampled on the previous edge (latency 1 cycle); decoder samples ≥3 cycles after address change, so no handshake.
- Read and write to the same address in one cycle: read returns the old value.
- evt_i[n] high at edge t → INT_PEND[n]=1 after t → fpga_int_out high after t+1 if masked-in (2-cycle latency); W1C clear or mask write drops fpga_int_out with the same 2-cycle latency.
- sts_i → STATUS readback: 1 register stage, then 1 read stage.
- WR_CNT and ERR_CNT increment by at most 1 per cycle (one write strobe per cycle).

## Structure
- Shared package spi_reg_pkg: address constants (ADDR_ID, ADDR_SCRATCH, ADDR_INT_PEND, ADDR_INT_MASK, ADDR_STATUS, ADDR_WR_CNT, ADDR_ERR_CNT, CTRL_BASE) and default ID_VALUE, used also by host-side test software headers.
- One sub-module: spi_reg_irq (INT_PEND, INT_MASK, W1C/event priority, registered interrupt output). Address decode, counters, control array and read mux stay in the top.

## Test plan
- Reset then read 0x0000 and 0x0003 → 0x4A45, 0x0000; fpga_int_out=0; ctrl_o all 0.
- Write 0x1234 to 0x0001, read back → 0x1234 one cycle after address; WR_CNT=1.
- INT_MASK=0x0001, pulse evt_i[0] → fpga_int_out high 2 cycles later; write 0x0001 to 0x0002 in same cycle as another evt_i[0] → INT_PEND[0] stays 1, interrupt stays high; next clear with no event → low 2 cycles later.
- Write CTRL[3] (addr 0x0013) = 0xBEEF → ctrl_o[63:48]=0xBEEF and ctrl_upd_o=0x0008 for exactly one cycle.
- Write to 0x0000, 0x0004 and 0x7FFF → values unchanged, ERR_CNT=3, WR_CNT unchanged; preload near 0xFFFF via 65535+ bad writes → ERR_CNT holds 0xFFFF.
- Assert reset_i during a burst of writes → all registers return to reset values, write in reset cycle lost.
